// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply/divide sequencer that borrows the core ALU's adder.
// Unsigned shift-add multiply (WIDTH x WIDTH -> 2*WIDTH) and restoring divide,
// one iteration per clock, results returned as {hi, lo} with a done pulse.
//
// Handshake: start is sampled only while idle (busy low); op/opa/opb are captured
// on that same edge. busy stays high until the single-cycle done pulse ends, and
// any start seen while busy is dropped. result_hi/lo/div0 are valid while done is
// high and hold until the next operation completes.
module alu_muldiv_seq #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   DIV0_QUOT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div0,
    output logic [1:0]       state_dbg
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [3:0]     ALU_ADD = 4'b0000;
    localparam logic [3:0]     ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // acc_q  : product high half (multiply) / partial remainder (divide)
    // lo_q   : multiplier being shifted out (multiply) / dividend->quotient (divide)
    // opnd_q : multiplicand (multiply) / divisor (divide)
    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    logic [WIDTH-1:0] rs;
    logic             ge;
    logic             carry;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] lo_n;

    // ALU drive: derived only from registered state, zero whenever not iterating
    always_comb begin
        alu_in0    = '0;
        alu_in1    = '0;
        alu_select = ALU_ADD;
        rs         = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
        // acc_q[MSB] is the 17th bit of the shifted remainder; if set it always exceeds D
        ge         = acc_q[WIDTH-1] | (rs >= opnd_q);
        // adder wrapped iff the sum came out smaller than an addend
        carry      = (alu_out < acc_q);
        if (state_q == S_RUN) begin
            if (op_q) begin
                alu_select = ALU_SUB;
                alu_in0    = rs;
                alu_in1    = opnd_q;
            end else if (lo_q[0]) begin
                alu_select = ALU_ADD;
                alu_in0    = acc_q;
                alu_in1    = opnd_q;
            end
        end
    end

    // One iteration of the selected algorithm, using the ALU result this cycle
    always_comb begin
        acc_n = acc_q;
        lo_n  = lo_q;
        if (op_q) begin
            acc_n = ge ? alu_out : rs;
            lo_n  = {lo_q[WIDTH-2:0], ge};
        end else if (lo_q[0]) begin
            {acc_n, lo_n} = {carry, alu_out, lo_q[WIDTH-1:1]};
        end else begin
            {acc_n, lo_n} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
        end
    end

    // Next-state and registered-output logic of the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        div0_d   = div0_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    div0_d = 1'b0;
                    if (op && (opb == '0)) begin
                        state_d  = S_DONE;
                        res_lo_d = DIV0_QUOT;
                        res_hi_d = opa;
                        div0_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        count_d = '0;
                        acc_d   = '0;
                        lo_d    = op ? opa : opb;
                        opnd_d  = op ? opb : opa;
                    end
                end
            end
            S_RUN: begin
                acc_d   = acc_n;
                lo_d    = lo_n;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d  = S_DONE;
                    res_hi_d = acc_n;
                    res_lo_d = lo_n;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vector table, randomized ops against an
// arithmetic reference model, plus hand sequences for ignored start and abort.
// Latency is counted in rising edges from the edge that samples start,
// inclusive of that edge: 17 for a normal op, 1 for the direct divide-by-zero path.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic [15:0] alu_in0, alu_in1, alu_out;
  logic [3:0]  alu_select;
  logic        busy, done, div0;
  logic [15:0] result_hi, result_lo;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int bad_sel = 0;
  int bad_idle = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        d0;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  // ALU beside the sequencer: combinational add/sub
  assign alu_out = (alu_select == 4'b0001) ? (alu_in0 - alu_in1) : (alu_in0 + alu_in1);

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select), .alu_out(alu_out),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div0(div0), .state_dbg(state_dbg)
  );

  // Only add/sub may be selected; the ALU lines must be quiet while idle
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_select > 4'b0001) bad_sel++;
      if (!busy && (alu_in0 != 16'h0 || alu_in1 != 16'h0 || alu_select != 4'h0)) bad_idle++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [32:0] model(input logic o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!o) begin
      p = {16'h0, a} * {16'h0, b};
      return {1'b0, p};
    end
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    return {1'b0, a % b, a / b};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one op; optionally pulses a spurious start with other operands when
  // 'poke_at' edges have passed since sampling (i.e. during RUN count poke_at).
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input int poke_at,
                        output logic [15:0] hi, output logic [15:0] lo,
                        output logic d0, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); opa = 16'($urandom); opb = 16'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat - 1 == poke_at) begin
        @(negedge clk);
        start = 1'b1; op = ~o; opa = 16'($urandom); opb = 16'h0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    hi = result_hi;
    lo = result_lo;
    d0 = div0;
    chk("busy_with_done", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("busy_after_done", {31'h0, busy}, 32'h0);
    chk("results_held", {result_hi, result_lo}, {hi, lo});
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] hi, lo;
    logic        d0;
    int          lat;
    logic        o;
    logic [15:0] a, b;
    logic [32:0] e;
    int          n_done;

    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[2] = '{1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};
    vecs[5] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[6] = '{1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_div0", {31'h0, div0}, 32'h0);
    chk("rst_result", {result_hi, result_lo}, 32'h0);
    chk("rst_alu", {alu_in0, alu_in1}, 32'h0);
    chk("rst_alu_sel", {28'h0, alu_select}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, hi, lo, d0, lat);
      chk($sformatf("vec%0d_result", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("vec%0d_div0", i), {31'h0, d0}, {31'h0, vecs[i].d0});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (i % 10 == 0) b = 16'h0001;
      exp_q.push_back(model(o, a, b));
      run_op(o, a, b, -1, hi, lo, d0, lat);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_result", i), {hi, lo}, e[31:0]);
      chk($sformatf("rnd%0d_div0", i), {31'h0, d0}, {31'h0, e[32]});
      chk($sformatf("rnd%0d_latency", i), lat, (o && b == 16'h0) ? 1 : 17);
    end

    // start pulsed during RUN count 5 with new operands must be ignored
    e = model(1'b0, 16'h1234, 16'h00FF);
    run_op(1'b0, 16'h1234, 16'h00FF, 5, hi, lo, d0, lat);
    chk("poke_result", {hi, lo}, e[31:0]);
    chk("poke_latency", lat, 17);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("poke_no_extra_done", n_done, 0);

    // reset asserted at RUN count 8 aborts the operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 16'hABCD; opb = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", {result_hi, result_lo}, 32'h0);
    chk("abort_alu", {alu_in0, alu_in1}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    chk("abort_quiet", n_done, 0);
    run_op(1'b0, 16'h0002, 16'h0002, -1, hi, lo, d0, lat);
    chk("after_abort_result", {hi, lo}, 32'h0000_0004);
    chk("after_abort_latency", lat, 17);

    chk("alu_select_legal", bad_sel, 0);
    chk("alu_quiet_when_idle", bad_idle, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
